// File: rtl/wb_regfile.sv
// Integer register file with write-back port, two read ports and a debug port.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to readers.
module wb_regfile #(
    parameter int REG_NUM    = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wb_wd,
    input  logic                  wb_wreg,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  re2,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic                  wb_en;
    logic                  accept;
    logic [DATA_WIDTH-1:0] dbg_rd;

    assign wb_en = wb_wreg && (wb_wd != '0);

    function automatic logic [DATA_WIDTH-1:0] rd_port(
        input logic                  en,
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (en && a != '0) begin
            v = regs[a];
`ifdef REGFILE_BYPASS_EN
            if (wb_en && a == wb_wd) v = wb_wdata;
`endif
        end
        return v;
    endfunction

    always_comb begin
        rdata1 = rd_port(re1, raddr1);
        rdata2 = rd_port(re2, raddr2);
        dbg_rd = rd_port(1'b1, dbg_addr);
    end

    // Debug writes yield to write-back; reads are never blocked.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (dbg_req && (!dbg_we || !wb_wreg)) begin
                    accept    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: state_nxt = IDLE;
        endcase
    end

    assign dbg_ack = (state == ACK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dbg_rdata <= '0;
        else if (accept && !dbg_we)
            dbg_rdata <= dbg_rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_wd] <= wb_wdata;
        end else if (accept && dbg_we && dbg_addr != '0) begin
            regs[dbg_addr] <= dbg_wdata;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps plus randomized traffic
// checked against an array-based reference model.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [32];
    logic [31:0] m_dbg_rdata;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .wb_wd    (wb_wd),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .dbg_req  (dbg_req),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_ack  (dbg_ack),
        .dbg_rdata(dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic en, input logic [4:0] a);
        if (!en || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wb_wreg && wb_wd != 5'd0 && a == wb_wd) return wb_wdata;
`endif
        return mregs[a];
    endfunction

    task automatic mreset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        m_dbg_rdata = 32'd0;
    endtask

    // Advance one clock and apply the write-back rule to the model.
    task automatic tick();
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        w = wb_wreg;
        a = wb_wd;
        d = wb_wdata;
        @(posedge clk);
        if (w && a != 5'd0) mregs[a] = d;
        #1;
    endtask

    task automatic check_all(input string tag);
        re1 = 1'b1;
        re2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check({tag, "_p1"}, rdata1, mread(1'b1, raddr1));
            check({tag, "_p2"}, rdata2, mread(1'b1, raddr2));
        end
    endtask

    task automatic dbg_op(input logic we, input logic [4:0] addr,
                          input logic [31:0] wd);
        logic        done;
        logic [31:0] exp_rd;
        done      = 1'b0;
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wd;
        for (int c = 0; c < 20 && !done; c++) begin
            wb_wreg  = (c < 3) ? 1'($urandom) : 1'b0;
            wb_wd    = 5'($urandom);
            wb_wdata = $urandom;
            #1;
            check("dbg_wait_ack", {31'd0, dbg_ack}, 32'd0);
            done   = !we || !wb_wreg;
            exp_rd = mread(1'b1, addr);
            tick();
            if (done) begin
                if (we && addr != 5'd0) mregs[addr] = wd;
                if (!we) m_dbg_rdata = exp_rd;
            end
        end
        check("dbg_accepted", {31'd0, done}, 32'd1);
        dbg_req = 1'b0;
        wb_wreg = 1'b0;
        #1;
        check("dbg_ack_pulse", {31'd0, dbg_ack}, 32'd1);
        check("dbg_rdata", dbg_rdata, m_dbg_rdata);
        tick();
        check("dbg_ack_end", {31'd0, dbg_ack}, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        wb_wd     = '0;
        wb_wreg   = 1'b0;
        wb_wdata  = '0;
        re1       = 1'b0;
        raddr1    = '0;
        re2       = 1'b0;
        raddr2    = '0;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
        mreset();
        #12;
        check("rst_ack", {31'd0, dbg_ack}, 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);
        rst = 1'b1;
        tick();
        check_all("reset_regs");

        // x5 write, visible on the following cycle
        wb_wreg  = 1'b1;
        wb_wd    = 5'd5;
        wb_wdata = 32'hDEADBEEF;
        re1      = 1'b1;
        raddr1   = 5'd5;
        #1;
        check("x5_same_cycle", rdata1, mread(1'b1, 5'd5));
        tick();
        wb_wreg = 1'b0;
        #1;
        check("x5_next_cycle", rdata1, 32'hDEADBEEF);

        // write-back to x0 is dropped
        wb_wreg  = 1'b1;
        wb_wd    = 5'd0;
        wb_wdata = 32'h12345678;
        tick();
        wb_wreg = 1'b0;
        check_all("x0_write");

        // same-cycle write x7 observed on port 2
        wb_wreg  = 1'b1;
        wb_wd    = 5'd7;
        wb_wdata = 32'hA5A5A5A5;
        re2      = 1'b1;
        raddr2   = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x7_bypass", rdata2, 32'hA5A5A5A5);
`else
        check("x7_old", rdata2, 32'd0);
`endif
        tick();
        wb_wreg = 1'b0;
        #1;
        check("x7_next", rdata2, 32'hA5A5A5A5);

        // read enable low masks the data
        re1    = 1'b0;
        raddr1 = 5'd5;
        #1;
        check("re1_off", rdata1, 32'd0);
        re1 = 1'b1;

        // debug write held off by three write-back cycles
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 5'd10;
        dbg_wdata = 32'h55AA;
        for (int c = 0; c < 3; c++) begin
            wb_wreg  = 1'b1;
            wb_wd    = 5'd3;
            wb_wdata = $urandom;
            #1;
            check("dbgw_busy_ack", {31'd0, dbg_ack}, 32'd0);
            tick();
        end
        wb_wreg = 1'b0;
        #1;
        check("dbgw_idle_ack", {31'd0, dbg_ack}, 32'd0);
        tick();
        mregs[10] = 32'h55AA;
        dbg_req   = 1'b0;
        #1;
        check("dbgw_ack", {31'd0, dbg_ack}, 32'd1);
        tick();
        check("dbgw_ack_drop", {31'd0, dbg_ack}, 32'd0);
        raddr1 = 5'd10;
        #1;
        check("x10_value", rdata1, 32'h55AA);
        check("x3_value", rdata1 ^ rdata1 ^ mregs[3], mregs[3]);
        raddr1 = 5'd3;
        #1;
        check("x3_readback", rdata1, mregs[3]);

        // debug read of x10
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 5'd10;
        #1;
        check("dbgr_pre_ack", {31'd0, dbg_ack}, 32'd0);
        tick();
        dbg_req = 1'b0;
        #1;
        check("dbgr_ack", {31'd0, dbg_ack}, 32'd1);
        check("dbgr_data", dbg_rdata, 32'h55AA);
        m_dbg_rdata = 32'h55AA;
        tick();
        check("dbgr_ack_drop", {31'd0, dbg_ack}, 32'd0);
        check("dbgr_hold", dbg_rdata, 32'h55AA);

        // randomized traffic with interleaved debug operations
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                dbg_op(1'($urandom), 5'($urandom), $urandom);
            end else begin
                wb_wreg  = 1'($urandom);
                wb_wd    = 5'($urandom);
                wb_wdata = $urandom;
                re1      = ($urandom_range(0, 3) != 0);
                re2      = ($urandom_range(0, 3) != 0);
                raddr1   = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom);
                raddr2   = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom);
                #1;
                check("rand_p1", rdata1, mread(re1, raddr1));
                check("rand_p2", rdata2, mread(re2, raddr2));
                check("rand_ack", {31'd0, dbg_ack}, 32'd0);
                tick();
            end
        end
        wb_wreg = 1'b0;
        check_all("rand_final");

        // reset in the middle of a pending debug write
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 5'd12;
        dbg_wdata = 32'hCAFEF00D;
        wb_wreg   = 1'b1;
        wb_wd     = 5'd9;
        wb_wdata  = 32'h0BADF00D;
        tick();
        #2;
        rst = 1'b0;
        mreset();
        #1;
        check("midrst_ack", {31'd0, dbg_ack}, 32'd0);
        check("midrst_dbg_rdata", dbg_rdata, 32'd0);
        dbg_req = 1'b0;
        wb_wreg = 1'b0;
        check_all("midrst_regs");
        rst = 1'b1;
        tick();
        check("postrst_ack", {31'd0, dbg_ack}, 32'd0);
        tick();
        check("postrst_ack2", {31'd0, dbg_ack}, 32'd0);
        check_all("postrst_regs");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
